// File: rtl/revaluate_sequencer_if.sv
// Host and datapath handshake bundle for the revaluate sequencer.
// master: sequencer side (drives strobes/status); slave: host + datapath side.
interface revaluate_sequencer_if #(
    parameter int ROUND_W = 5
);
    logic               start;
    logic               abort;
    logic               dp_done;
    logic               dp_count;
    logic               dp_write;
    logic               dp_clear;
    logic               load_en;
    logic               load_sel;
    logic               busy;
    logic               done;
    logic               error;
    logic [ROUND_W-1:0] round;

    modport master (
        input  start, abort, dp_done,
        output dp_count, dp_write, dp_clear,
        output load_en, load_sel,
        output busy, done, error, round
    );

    modport slave (
        output start, abort, dp_done,
        input  dp_count, dp_write, dp_clear,
        input  load_en, load_sel,
        input  busy, done, error, round
    );
endinterface

// File: rtl/revaluate_sequencer.sv
// Sequences NUM_ROUNDS full cell sweeps of the chi-revaluate datapath.
// Ports: clk, rst (async active-low), bus (master: start/abort/dp_done in; strobes/status out).
module revaluate_sequencer #(
    parameter int NUM_CELLS  = 1600,
    parameter int NUM_ROUNDS = 24,
    parameter int CNT_W      = 11,
    parameter int ROUND_W    = 5
) (
    input  logic clk,
    input  logic rst,
    revaluate_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        COMMIT,
        FINISH,
        ERROR
    } state_t;

    localparam logic [CNT_W-1:0]   LAST_CELL  = CNT_W'(NUM_CELLS - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [ROUND_W-1:0] round_q;
    logic [ROUND_W-1:0] round_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        unique case (state_q)
            IDLE, ERROR: begin
                if (bus.start) begin
                    state_d = LOAD;
                    round_d = '0;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort wins over any dp_done verdict
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CELL) begin
                    cnt_d   = '0;
                    state_d = bus.dp_done ? COMMIT : ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.dp_done) begin
                        state_d = ERROR;
                    end
                end
            end
            COMMIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = '0;
                    if (round_q == LAST_ROUND) begin
                        state_d = FINISH;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = RUN;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dp_count = (state_q == RUN);
    assign bus.dp_write = (state_q == RUN);
    assign bus.dp_clear = (state_q == LOAD) || (state_q == COMMIT);
    assign bus.load_en  = (state_q == LOAD) || (state_q == COMMIT);
    assign bus.load_sel = (state_q == COMMIT);
    assign bus.busy     = (state_q == LOAD) || (state_q == RUN)
                       || (state_q == COMMIT);
    assign bus.done     = (state_q == FINISH);
    assign bus.error    = (state_q == ERROR);
    assign bus.round    = round_q;
endmodule

// File: tb/tb_revaluate_sequencer.sv
// Directed table-driven bench for revaluate_sequencer (4 cells, 3 rounds).
// Rows: inputs applied before an edge, outputs checked 1 time unit after it.
module tb_revaluate_sequencer;
    localparam int NC = 4;
    localparam int NR = 3;
    localparam int CW = 2;
    localparam int RW = 2;

    // {dp_count,dp_write,dp_clear,load_en,load_sel,busy,done,error}
    localparam logic [7:0] O_IDLE = 8'h00;
    localparam logic [7:0] O_LOAD = 8'h34;
    localparam logic [7:0] O_RUN  = 8'hC4;
    localparam logic [7:0] O_CMT  = 8'h3C;
    localparam logic [7:0] O_FIN  = 8'h02;
    localparam logic [7:0] O_ERR  = 8'h01;

    typedef struct {
        logic          start;
        logic          abort;
        logic          dd;
        logic [7:0]    exp;
        logic [RW-1:0] rnd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    revaluate_sequencer_if #(.ROUND_W(RW)) bus ();

    revaluate_sequencer #(
        .NUM_CELLS (NC),
        .NUM_ROUNDS(NR),
        .CNT_W     (CW),
        .ROUND_W   (RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.dp_count, bus.dp_write, bus.dp_clear, bus.load_en,
                bus.load_sel, bus.busy, bus.done, bus.error};
    endfunction

    task automatic add(input logic s, input logic a, input logic d,
                       input logic [7:0] e, input int r);
        vec_t v;
        v.start = s;
        v.abort = a;
        v.dd    = d;
        v.exp   = e;
        v.rnd   = RW'(r);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] e,
                         input logic [RW-1:0] r);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL %s outputs: got %h want %h", name, outs(), e);
        end
        checks++;
        if (bus.round !== r) begin
            errors++;
            $display("FAIL %s round: got %0d want %0d", name, bus.round, r);
        end
    endtask

    initial begin
        string nm;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.dp_done = 1'b0;

        // nominal 3-pass job; start during RUN is ignored
        add(1, 0, 0, O_LOAD, 0);
        add(0, 0, 0, O_RUN, 0);
        add(1, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 1, O_CMT, 0);
        add(0, 0, 0, O_RUN, 1);
        add(0, 0, 0, O_RUN, 1);
        add(0, 0, 0, O_RUN, 1);
        add(0, 0, 0, O_RUN, 1);
        add(0, 0, 1, O_CMT, 1);
        add(0, 0, 0, O_RUN, 2);
        add(0, 0, 0, O_RUN, 2);
        add(0, 0, 0, O_RUN, 2);
        add(0, 0, 0, O_RUN, 2);
        add(0, 0, 1, O_CMT, 2);
        add(0, 0, 0, O_FIN, 2);
        add(0, 0, 0, O_IDLE, 2);
        // start+abort in IDLE: start wins; early done -> ERROR
        add(1, 1, 0, O_LOAD, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 1, O_ERR, 0);
        add(0, 0, 0, O_ERR, 0);
        // start+abort in ERROR; then missing done -> ERROR
        add(1, 1, 0, O_LOAD, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_ERR, 0);
        // abort with dp_done in RUN of round 1
        add(1, 0, 0, O_LOAD, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 1, O_CMT, 0);
        add(0, 0, 0, O_RUN, 1);
        add(0, 0, 0, O_RUN, 1);
        add(0, 1, 1, O_IDLE, 1);
        add(0, 0, 1, O_IDLE, 1);
        // abort in COMMIT, then abort in LOAD
        add(1, 0, 0, O_LOAD, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 0, O_RUN, 0);
        add(0, 0, 1, O_CMT, 0);
        add(0, 1, 0, O_IDLE, 0);
        add(1, 0, 0, O_LOAD, 0);
        add(0, 1, 0, O_IDLE, 0);

        #12;
        check("in_reset", O_IDLE, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("after_reset", O_IDLE, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.start   = tbl[i].start;
            bus.abort   = tbl[i].abort;
            bus.dp_done = tbl[i].dd;
            @(posedge clk);
            #1;
            nm = $sformatf("row%0d", i);
            check(nm, tbl[i].exp, tbl[i].rnd);
        end

        // async reset dropped mid-COMMIT, between edges
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.dp_done = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.dp_done = 1'b1;
        @(posedge clk);
        #1;
        bus.dp_done = 1'b0;
        check("pre_reset_commit", O_CMT, '0);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", O_IDLE, '0);
        @(negedge clk);
        rst = 1'b1;
        bus.dp_done = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ignores_done1", O_IDLE, '0);
        @(posedge clk);
        #1;
        check("idle_ignores_done2", O_IDLE, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
